// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit unsigned subtractor (a - b), LSB first, one bit per
//   clock through a single full-subtractor cell. A start/done handshake
//   launches an operation and flags its completion. DiffBout carries the
//   WIDTH-bit difference with the borrow-out in its MSB.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN
//     When defined, adds output 'ovf': two's-complement overflow of a - b,
//     registered together with DiffBout at completion.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   DiffBout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // One full-subtractor cell: returns {borrow_out, difference}.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
      logic d;
      logic bout;
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
      return {bout, d};
   endfunction

   state_t             state_r;
   state_t             state_nx_s;
   logic [WIDTH-1:0]   a_sh_r;
   logic [WIDTH-1:0]   b_sh_r;
   logic [WIDTH-1:0]   diff_sh_r;
   logic               br_r;
   logic [CNT_W-1:0]   count_r;
   logic               load_s;
   logic               shift_s;
   logic               finish_s;
   logic [1:0]         fs_s;

   // The single cell evaluated on the current LSBs and the stored borrow.
   always_comb begin
      fs_s = full_sub(a_sh_r[0], b_sh_r[0], br_r);
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      shift_s    = 1'b0;
      finish_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new start exactly like IDLE (back-to-back).
            if (start) begin
               load_s     = 1'b1;
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            shift_s = 1'b1;
            if (count_r == LAST_CNT) begin
               finish_s   = 1'b1;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Operand/difference shift registers, borrow flop and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r    <= '0;
         b_sh_r    <= '0;
         diff_sh_r <= '0;
         br_r      <= 1'b0;
         count_r   <= '0;
      end else if (load_s) begin
         a_sh_r    <= a;
         b_sh_r    <= b;
         diff_sh_r <= '0;
         br_r      <= 1'b0;
         count_r   <= '0;
      end else if (shift_s) begin
         a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
         diff_sh_r <= {fs_s[0], diff_sh_r[WIDTH-1:1]};
         br_r      <= fs_s[1];
         count_r   <= count_r + CNT_W'(1);
      end else begin
         a_sh_r    <= a_sh_r;
         b_sh_r    <= b_sh_r;
         diff_sh_r <= diff_sh_r;
         br_r      <= br_r;
         count_r   <= count_r;
      end
   end

   // Result register: only updated on the edge that processes the last bit,
   // so no partial difference is ever visible on DiffBout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DiffBout <= '0;
      end else if (finish_s) begin
         DiffBout <= {fs_s[1], fs_s[0], diff_sh_r[WIDTH-1:1]};
      end else begin
         DiffBout <= DiffBout;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Signed overflow: on the final bit a_sh_r[0]/b_sh_r[0] are the operand
   // sign bits and fs_s[0] is the result sign bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (finish_s) begin
         ovf <= (a_sh_r[0] != b_sh_r[0]) && (fs_s[0] != a_sh_r[0]);
      end else begin
         ovf <= ovf;
      end
   end
`endif

   // Registered handshake outputs derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         ready <= (state_nx_s != ST_RUN);
         busy  <= (state_nx_s == ST_RUN);
         done  <= finish_s;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor (WIDTH=7).
//   Define SERIAL_SUB_OVF_EN on both bench and RTL to exercise the ovf port.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [6:0] a;
   logic [6:0] b;
   logic       ready;
   logic       busy;
   logic       done;
   logic [7:0] DiffBout;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   serial_subtractor #(.WIDTH(7)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .DiffBout (DiffBout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf      (ovf)
`endif
   );

   // Free-running clock, rising edge at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One operation with start pulse; RUN-time start pulses and operand changes
   // must be ignored. Checks latency, busy length, DiffBout stability, result.
   task automatic run_op(input string tag, input logic [6:0] av, input logic [6:0] bv,
                         input logic [7:0] exp_d, input logic exp_o);
      int         k;
      int         busy_n;
      logic       stable;
      logic [7:0] prev;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      prev  = DiffBout;
      @(negedge clk);
      k      = 1;
      busy_n = 0;
      stable = 1'b1;
      while (!done && k < 20) begin
         if (busy) busy_n++;
         if (DiffBout !== prev) stable = 1'b0;
         start = (k == 3);
         a     = 7'($urandom);
         b     = 7'($urandom);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check({tag, "_latency"}, k, 8);
      check({tag, "_busy_cycles"}, busy_n, 7);
      check({tag, "_no_partial"}, stable, 1);
      check({tag, "_diff"}, DiffBout, exp_d);
      check({tag, "_ready_in_done"}, ready, 1);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, ovf, exp_o);
`else
      if (exp_o === 1'bx) $display("unexpected ovf expectation");
`endif
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_idle_after"}, {ready, busy}, 2'b10);
      check({tag, "_hold"}, DiffBout, exp_d);
   endtask

   initial begin
      int d_at[3];
      int nd;
      rst_n = 1'b1;
      start = 1'b0;
      a     = 7'd0;
      b     = 7'd0;

      // Asynchronous reset mid-cycle, before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", DiffBout, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("post_rst_no_done", nd, 0);
      check("post_rst_idle", {ready, busy}, 2'b10);

      // Directed vectors (ovf column: signed overflow of a-b on 7 bits).
      run_op("v100_37",  7'd100, 7'd37,  8'h3F, 1'b1);
      run_op("v5_9",     7'd5,   7'd9,   8'hFC, 1'b0);
      run_op("v0_127",   7'd0,   7'd127, 8'h81, 1'b0);
      run_op("v127_127", 7'd127, 7'd127, 8'h00, 1'b0);
      run_op("vm64_1",   7'h40,  7'h01,  8'h3F, 1'b1);
      run_op("v63_m1",   7'h3F,  7'h7F,  8'hC0, 1'b1);
      run_op("v3_1",     7'd3,   7'd1,   8'h02, 1'b0);

      // Back-to-back: start held, operands valid only on accept edges.
      @(negedge clk);
      a     = 7'd100;
      b     = 7'd37;
      start = 1'b1;
      nd    = 0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (done) begin
            if (nd < 3) d_at[nd] = c;
            nd++;
            check("b2b_diff", DiffBout, 8'h3F);
         end
         if (c % 8 == 0) begin
            a     = 7'd100;
            b     = 7'd37;
            start = (c != 24);
         end else begin
            a     = 7'($urandom);
            b     = 7'($urandom);
            start = 1'($urandom);
         end
      end
      check("b2b_count", nd, 3);
      check("b2b_first", d_at[0], 8);
      check("b2b_second", d_at[1], 16);
      check("b2b_third", d_at[2], 24);
      @(negedge clk);
      check("b2b_end_done", done, 0);
      check("b2b_end_idle", {ready, busy}, 2'b10);

      // Abort with reset during RUN.
      a     = 7'd5;
      b     = 7'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_diff", DiffBout, 8'h00);
      check("abort_status", {ready, busy, done}, 3'b100);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("abort_no_done", nd, 0);
      check("abort_diff_held", DiffBout, 8'h00);
      run_op("after_abort", 7'd5, 7'd9, 8'hFC, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
